// File: rtl/ysyx_22041211_lsu_if.sv
// Memory-side request/response bus of the LSU: one request channel with
// valid/ready and a response strobe carrying read data (or a write ack).
interface ysyx_22041211_lsu_if #(
  parameter int DATA_LEN = 32
);
  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  logic [DATA_LEN-1:0] mem_addr_o;
  logic                mem_wen_o;
  logic [DATA_LEN-1:0] mem_wdata_o;
  logic [3:0]          mem_wmask_o;
  logic                mem_rsp_valid_i;
  logic [DATA_LEN-1:0] mem_rdata_i;

  modport master (
    output mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
  );
endinterface

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit between EX and WB, one access in flight on the memory bus.
// Define YSYX_22041211_MISALIGN_CHK_EN to trap misaligned LH/LHU/SH/LW/SW.
//
// state | meaning
// IDLE  | ready_o=1, waiting for an EX op
// REQ   | memory request held on the bus until accepted
// WAIT  | request accepted, waiting for read data / write ack
// DONE  | result valid towards WB until ready_i
module ysyx_22041211_lsu #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic                misalign_o,
  ysyx_22041211_lsu_if.master mem
);
  // load_type: 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; store_type: 1 SB, 2 SH, 3 SW
  localparam logic [2:0] LD_NONE = 3'd0, LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3,
                         LD_LBU = 3'd4, LD_LHU = 3'd5;
  localparam logic [1:0] ST_NONE = 2'd0, ST_SB = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;

  logic [DATA_LEN-1:0] addr_q, sdata_q, csr_q, result_q, load_data;
  logic [2:0]          load_q;
  logic [1:0]          store_q;
  logic                wd_q, misalign_q, fire, mem_op, mis_in;
  logic [4:0]          wreg_q;
  logic [15:0]         lane;

  assign fire   = valid_i && (state_q == IDLE);
  assign mem_op = (load_type_i != LD_NONE) || (store_type_i != ST_NONE);

  always_comb begin
`ifdef YSYX_22041211_MISALIGN_CHK_EN
    if (load_type_i == LD_LH || load_type_i == LD_LHU) mis_in = alu_result_i[0];
    else if (load_type_i == LD_LW) mis_in = |alu_result_i[1:0];
    else if (load_type_i == LD_NONE && store_type_i == ST_SH) mis_in = alu_result_i[0];
    else if (load_type_i == LD_NONE && store_type_i == ST_SW) mis_in = |alu_result_i[1:0];
    else mis_in = 1'b0;
`else
    mis_in = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (valid_i) state_d = (mem_op && !mis_in) ? REQ : DONE;
      REQ:  if (mem.mem_req_ready_i) state_d = WAIT;
      WAIT: if (mem.mem_rsp_valid_i) state_d = DONE;
      DONE: if (ready_i) state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o             = (state_q == IDLE);
    valid_o             = (state_q == DONE);
    mem.mem_req_valid_o = (state_q == REQ);
    mem.mem_wen_o       = (state_q == REQ) && (store_q != ST_NONE);
    mem.mem_wmask_o     = 4'b0000;
    if (state_q == REQ) begin
      unique case (store_q)
        ST_SB:   mem.mem_wmask_o = 4'b0001 << addr_q[1:0];
        ST_SH:   mem.mem_wmask_o = 4'b0011 << addr_q[1:0];
        ST_SW:   mem.mem_wmask_o = 4'b1111;
        default: mem.mem_wmask_o = 4'b0000;
      endcase
    end
  end

  assign mem.mem_addr_o = {addr_q[DATA_LEN-1:2], 2'b00};

  always_comb begin
    unique case (store_q)
      ST_SB:   mem.mem_wdata_o = {4{sdata_q[7:0]}};
      ST_SH:   mem.mem_wdata_o = {2{sdata_q[15:0]}};
      default: mem.mem_wdata_o = sdata_q;
    endcase
  end

  // Bytes shifted past the top lane fall off, so misaligned halfwords zero-fill.
  assign lane = 16'(mem.mem_rdata_i >> {addr_q[1:0], 3'b000});

  always_comb begin
    unique case (load_q)
      LD_LB:   load_data = {{(DATA_LEN-8){lane[7]}}, lane[7:0]};
      LD_LH:   load_data = {{(DATA_LEN-16){lane[15]}}, lane};
      LD_LBU:  load_data = {{(DATA_LEN-8){1'b0}}, lane[7:0]};
      LD_LHU:  load_data = {{(DATA_LEN-16){1'b0}}, lane};
      default: load_data = mem.mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= '0;
      sdata_q    <= '0;
      csr_q      <= '0;
      result_q   <= '0;
      load_q     <= LD_NONE;
      store_q    <= ST_NONE;
      wd_q       <= 1'b0;
      wreg_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (fire) begin
        addr_q     <= alu_result_i;
        sdata_q    <= mem_wdata_i;
        csr_q      <= csr_wdata_i;
        result_q   <= mis_in ? '0 : alu_result_i;
        load_q     <= load_type_i;
        store_q    <= (load_type_i != LD_NONE) ? ST_NONE : store_type_i;
        wd_q       <= wd_i && !mis_in;
        wreg_q     <= wreg_i;
        misalign_q <= mis_in;
      end else if (state_q == WAIT && mem.mem_rsp_valid_i && load_q != LD_NONE) begin
        result_q <= load_data;
      end
    end
  end

  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = result_q;
  assign csr_wdata_o = csr_q;
  assign misalign_o  = misalign_q;
endmodule

// File: doc/ysyx_22041211_lsu.md
YSYX_22041211_LSU -- requirements
Module: ysyx_22041211_lsu

Interface
REQ-001 SHALL have parameter: DATA_LEN, 32, datapath width.
REQ-002 SHALL have port: clk  in  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: valid_i in 1 EX op valid; ready_o out 1 LSU can accept.
REQ-005 SHALL have ports: alu_result_i in 32 address/result; mem_wdata_i in 32 store data; load_type_i in 3 (0 = none); store_type_i in 2 (0 = none).
REQ-006 SHALL have ports: wd_i in 1, wreg_i in 5, csr_wdata_i in 32; each passes through to the same-named _o port.
REQ-007 SHALL have ports: valid_o out 1 WB result valid; ready_i in 1 WB accepts; wd_o out 1; wreg_o out 5; wdata_o out 32; csr_wdata_o out 32.
REQ-008 SHALL have ports: mem_req_valid_o out 1; mem_req_ready_i in 1; mem_addr_o out 32; mem_wen_o out 1; mem_wdata_o out 32; mem_wmask_o out 4.
REQ-009 SHALL have ports: mem_rsp_valid_i in 1; mem_rdata_i in 32; misalign_o out 1.

Function
REQ-010 SHALL implement FSM IDLE, REQ, WAIT, DONE; ready_o=1 only in IDLE.
REQ-011 SHALL capture all _i operands on valid_i&&ready_o; capture register holds them until return to IDLE.
REQ-012 SHALL transition IDLE->DONE for non-memory op (load_type_i=0, store_type_i=0); wdata_o=alu_result_i; latency 1 cycle.
REQ-013 SHALL transition IDLE->REQ for load or store; REQ holds mem_req_valid_o=1 with stable addr/wen/wdata/wmask until mem_req_ready_i; REQ->WAIT on handshake.
REQ-014 SHALL transition WAIT->DONE on mem_rsp_valid_i; load data latched that cycle; stores also wait for rsp (write ack), rdata ignored.
REQ-015 SHALL hold valid_o=1 and all _o result ports stable in DONE; DONE->IDLE on ready_i.
REQ-016 SHALL drive mem_addr_o={addr[31:2],2'b00}; mem_wen_o=1 for stores.
REQ-017 SHALL lane-align stores: SB wmask=4'b0001<<addr[1:0], data byte replicated to all lanes; SH wmask=4'b0011<<addr[1:0], halfword replicated; SW wmask=4'b1111; loads drive wmask=0.
REQ-018 SHALL extract loads by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW raw word.
REQ-019 SHALL ignore mem_rsp_valid_i outside WAIT and valid_i outside IDLE.
REQ-020 SHALL treat load_type_i!=0 together with store_type_i!=0 as load (store ignored).

Reset
REQ-021 SHALL, on posedge clk with rst=0, enter IDLE regardless of state, including REQ/WAIT mid-transaction.
REQ-022 SHALL reset outputs: valid_o=0, mem_req_valid_o=0, mem_wen_o=0, mem_wmask_o=0, misalign_o=0, wd_o=0, wreg_o=0, wdata_o=0, csr_wdata_o=0, mem_addr_o=0, mem_wdata_o=0; ready_o=1 after reset.
REQ-023 SHALL discard a response arriving after reset aborted its transaction.

Configuration
REQ-024 SHALL support macro YSYX_22041211_MISALIGN_CHK_EN.
REQ-025 SHALL, with macro defined, detect LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0: no bus request, IDLE->DONE, wd_o=0, wdata_o=0, misalign_o=1 for exactly the first DONE cycle.
REQ-026 SHALL, without macro, tie misalign_o=0 and issue misaligned accesses using the shifted masks, with upper out-of-word lanes dropped.

Verification
REQ-027 SHALL cover: non-mem op alu_result_i=0x1234, wd_i=1, wreg_i=5 -> valid_o next cycle, wdata_o=0x1234, wreg_o=5, no mem_req_valid_o.
REQ-028 SHALL cover: LB addr 0x80000003, mem_req_ready_i delayed 3 cycles, rdata 0x80FFFFFF -> mem_addr_o=0x80000000 held 4 cycles, wdata_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-029 SHALL cover: SH addr 0x80000002 data 0xABCD1234 -> mem_wmask_o=4'b1100, mem_wdata_o=0x12341234, mem_wen_o=1; valid_o only after rsp.
REQ-030 SHALL cover: DONE with ready_i=0 for 5 cycles -> valid_o and wdata_o stable, ready_o=0, new valid_i ignored.
REQ-031 SHALL cover: rst=0 in WAIT, then rsp arrives -> IDLE, valid_o stays 0, ready_o=1.
REQ-032 SHALL cover (macro defined): LW addr 0x80000002 -> no mem_req_valid_o, misalign_o=1 one cycle, wd_o=0.
